// File: rtl/pc_update_unit_if.sv
// Bus between the microprogram sequencer / branch logic and the PC update stage.
// master: sequencer side (drives strobes, observes PC state).
// slave:  the PC update unit itself.
interface pc_update_unit_if #(
  parameter int CNT_W = 32
);
  logic             branch_taken;
  logic             jump;
  logic             jalr;
  logic             target_load;
  logic [31:0]      target_in;
  logic             pc_write;
  logic             is_branch;
  logic             trap_ack;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic [31:0]      link_addr;
  logic             trap;
  logic [31:0]      bad_addr;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output branch_taken, jump, jalr, target_load, target_in,
           pc_write, is_branch, trap_ack,
    input  pc, pc_plus4, link_addr, trap, bad_addr,
           branch_count, taken_count
  );

  modport slave (
    input  branch_taken, jump, jalr, target_load, target_in,
           pc_write, is_branch, trap_ack,
    output pc, pc_plus4, link_addr, trap, bad_addr,
           branch_count, taken_count
  );
endinterface

// File: rtl/pc_update_unit.sv
// Program-counter update stage: captures a redirect target, commits the next PC
// (sequential, redirected or trap vector), traps on misaligned redirect targets
// until acknowledged, and counts committed / taken conditional branches.
module pc_update_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
  parameter int          CNT_W       = 32
) (
  input logic          clk,
  input logic          reset,
  pc_update_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      pc_val;
  logic [31:0]      target;
  logic [31:0]      link;
  logic [31:0]      bad;
  logic             trap_flag;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] tk_cnt;

  logic [31:0]      seq_pc;
  logic [31:0]      captured;
  logic             redirect;
  logic             misaligned;
  logic             trap_commit;

  // Sequential successor wraps naturally modulo 2^32.
  assign seq_pc      = pc_val + 32'd4;
  // JALR targets have bit 0 forced low on capture.
  assign captured    = bus.target_in & ~{31'd0, bus.jalr};
  assign redirect    = bus.jump | bus.branch_taken;
  assign misaligned  = (target[1:0] != 2'b00);
  // An ARMED commit that redirects to a misaligned target enters TRAP.
  assign trap_commit = (state == ARMED) && bus.pc_write && redirect && misaligned;

  assign bus.pc           = pc_val;
  assign bus.pc_plus4     = seq_pc;
  assign bus.link_addr    = link;
  assign bus.trap         = trap_flag;
  assign bus.bad_addr     = bad;
  assign bus.branch_count = br_cnt;
  assign bus.taken_count  = tk_cnt;

  // Control FSM with all PC, link, trap and statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc_val    <= RESET_PC;
      target    <= 32'd0;
      link      <= 32'd0;
      bad       <= 32'd0;
      trap_flag <= 1'b0;
      br_cnt    <= '0;
      tk_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // No target is held here, so every commit is sequential.
          if (bus.pc_write) begin
            pc_val <= seq_pc;
            if (bus.is_branch) begin
              br_cnt <= br_cnt + 1'b1;
              if (bus.branch_taken) tk_cnt <= tk_cnt + 1'b1;
            end
          end
          // Capture lands after this cycle's commit decision.
          if (bus.target_load) begin
            target <= captured;
            state  <= ARMED;
          end
        end

        ARMED: begin
          if (bus.pc_write) begin
            if (trap_commit) begin
              pc_val    <= TRAP_VECTOR;
              bad       <= target;
              trap_flag <= 1'b1;
              state     <= TRAP;
            end else if (redirect) begin
              pc_val <= target;
              link   <= seq_pc;
              state  <= IDLE;
            end else begin
              pc_val <= seq_pc;
              state  <= IDLE;
            end
            if (bus.is_branch) begin
              br_cnt <= br_cnt + 1'b1;
              if (bus.branch_taken && !misaligned) tk_cnt <= tk_cnt + 1'b1;
            end
          end
          // A simultaneous load re-arms with the new target unless we trapped.
          if (bus.target_load && !trap_commit) begin
            target <= captured;
            state  <= ARMED;
          end
        end

        TRAP: begin
          // Strobes are ignored until the sequencer acknowledges.
          if (bus.trap_ack) begin
            trap_flag <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          trap_flag <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
- Program-counter stage directly downstream of the branch decision logic.
- Consumes the branch-taken decision and microcode strobes. Captures the ALU-computed target and commits the next PC: sequential, redirected, or trap vector.
- Detects misaligned redirect targets and holds a trap state until the microprogram sequencer acknowledges it.
- Keeps wrap-around branch statistics counters for the debug bus.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned-target trap.
- CNT_W, 32, width of branch statistics counters.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- branch_taken  in  1  branch decision from branch decision logic (branch signal already folded in)
- jump  in  1  unconditional redirect (JAL/JALR), valid with pc_write
- jalr  in  1  target bit 0 forced to 0 on capture
- target_load  in  1  microcode strobe: capture target_in
- target_in  in  32  ALU-computed redirect target
- pc_write  in  1  microcode strobe: commit next PC (one-cycle pulse)
- is_branch  in  1  qualifies pc_write as a conditional-branch commit, for statistics
- trap_ack  in  1  sequencer acknowledge, leaves TRAP
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4, combinational, wraps modulo 2^32
- link_addr  out  32  pc + 4 registered at last redirect commit (rd value for JAL/JALR)
- trap  out  1  high throughout TRAP state
- bad_addr  out  32  offending target latched on trap entry
- branch_count  out  CNT_W  committed conditional branches
- taken_count  out  CNT_W  committed taken conditional branches

Behaviour:
- Reset values: pc=RESET_PC; link_addr=0, bad_addr=0, branch_count=0, taken_count=0; trap=0; state=IDLE; target register=0.
- Reset asserted mid-operation aborts any ARMED or TRAP state with no commit.
- States: IDLE, ARMED, TRAP.
- IDLE:
  - target_load=1 captures target_in (bit 0 cleared if jalr) and moves to ARMED.
  - pc_write=1 without target_load gives pc<=pc+4 and stays in IDLE.
  - target_load and pc_write both high: the capture happens, the commit uses the sequential path (pc+4), and the state goes to ARMED. The new target is not usable the same cycle.
- ARMED:
  - target_load again overwrites the target; stays ARMED.
  - pc_write=1 with redirect = jump | branch_taken:
    - target[1:0]==2'b00: pc<=target, link_addr<=pc+4, go to IDLE.
    - Otherwise: pc<=TRAP_VECTOR, bad_addr<=target, go to TRAP. link_addr is unchanged.
  - pc_write=1 with no redirect: pc<=pc+4, target discarded, go to IDLE.
  - target_load and pc_write both high: commit uses the previously held target; the new value is captured and the state stays ARMED.
- TRAP:
  - trap=1. pc_write and target_load are ignored.
  - trap_ack=1 moves to IDLE next cycle. trap falls in the same cycle as the state change.
- Latency: pc updates on the clock edge where pc_write is sampled. The new pc is visible one cycle after the strobe.
- Statistics:
  - A commit with is_branch=1 in IDLE or ARMED increments branch_count.
  - taken_count increments only if branch_taken=1 and no trap results.
  - A trapping branch increments branch_count only.
  - jump commits are not counted unless is_branch=1.
  - Counters wrap at 2^CNT_W with no saturation.
- Arithmetic: pc+4 wraps modulo 2^32. A sequential step from 32'hFFFF_FFFC gives 32'h0000_0000 with no trap.
- Unqualified inputs (branch_taken, jump, is_branch) are don't-care when pc_write=0.

Test Plan:
- Reset, then three pc_write pulses -> pc 0x0, 0x4, 0x8, 0xC; all counters 0; trap=0.
- pc=0x40; target_load target_in=0x80; pc_write is_branch=1 branch_taken=1 -> pc=0x80, link_addr=0x44, branch_count=1, taken_count=1.
- target_load target_in=0x200; pc_write is_branch=1 branch_taken=0 from pc=0x80 -> pc=0x84, branch_count=2, taken_count=1, state IDLE.
- jalr=1 jump=1 target_in=0x103 -> captured 0x102 -> trap=1, pc=0x100, bad_addr=0x102. pc_write during TRAP leaves pc unchanged. trap_ack -> trap=0 next cycle.
- pc forced to 0xFFFF_FFFC via redirect, then sequential pc_write -> pc=0x0000_0000, no trap. Counter preloaded to all-ones by 2^32 branches (or CNT_W=4 override, 16 branches) -> branch_count wraps to 0.
- Reset asserted while ARMED with target 0x500 -> pc=RESET_PC immediately (asynchronous). A following pc_write gives pc=0x4, not 0x500.
